// File: rtl/myproject_sdiv_20s_10s_12_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
//   master : the side that supplies operands and consumes results
//   slave  : the divider itself
//   in_valid/in_ready/dividend/divisor          - operand channel
//   out_valid/out_ready/quotient/remainder/
//   div_by_zero/overflow                        - result channel
interface myproject_sdiv_20s_10s_12_seq_if #(
    parameter int DW = 20,
    parameter int VW = 10,
    parameter int QW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/myproject_sdiv_20s_10s_12_seq.sv
// Sequential signed divider, radix-2 restoring, one quotient bit per clock.
// Dividend (20s) / divisor (10s) -> quotient (12s, truncated toward zero,
// saturated) and remainder (10s, sign of the dividend).
// Ports:
//   ap_clk  - clock, rising edge
//   ap_rst  - synchronous active-high reset
//   bus     - slave side of the operand/result handshake bundle
// Flow: IDLE -accept-> CALC (DIVIDEND_WIDTH steps) -> FIN (sign/saturate)
//       -> DONE (hold result until out_ready) -> IDLE.
module myproject_sdiv_20s_10s_12_seq #(
    parameter int DIVIDEND_WIDTH = 20,
    parameter int DIVISOR_WIDTH  = 10,
    parameter int QUOTIENT_WIDTH = 12
) (
    input  logic ap_clk,
    input  logic ap_rst,
    myproject_sdiv_20s_10s_12_seq_if.slave bus
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int CW = $clog2(DW);

    // Largest quotient magnitudes representable for positive / negative results.
    localparam int QMAX_MAG = (1 << (QW - 1)) - 1;
    localparam int QMIN_MAG = (1 << (QW - 1));
    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
    logic [VW-1:0] rem_q, rem_d;     // partial remainder, always < |divisor|
    logic [VW-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic          sn_q, sn_d;       // dividend sign
    logic          sd_q, sd_d;       // divisor sign
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [QW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    // Magnitudes are held as unsigned values of the operand width: the most
    // negative operand (-2^19, -2^9) maps to 2^19 / 2^9, which still fits
    // an unsigned register of the same width, so no wrap occurs.
    logic [DW-1:0] dvd_mag;
    logic [VW-1:0] dvs_mag;
    logic [VW:0]   shifted;
    logic          take;
    logic          neg;

    assign dvd_mag = bus.dividend[DW-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = bus.divisor[VW-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        sn_d    = sn_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        neg     = sn_q ^ sd_q;
        // Trial step: bring in the next dividend bit, subtract if it fits.
        shifted = {rem_q, quo_q[DW-1]};
        take    = (shifted >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    sn_d    = bus.dividend[DW-1];
                    sd_d    = bus.divisor[VW-1];
                    rem_d   = '0;
                    cnt_d   = CW'(DW - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d = {quo_q[DW-2:0], take};
                rem_d = take ? VW'(shifted - {1'b0, dvs_q}) : VW'(shifted);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIN;
            end
            FIN: begin
                if (dvs_q == '0) begin
                    // Divide by zero: saturate toward the dividend's sign.
                    q_d   = sn_q ? QMIN : QMAX;
                    r_d   = '0;
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    dbz_d = 1'b0;
                    r_d   = sn_q ? (~rem_q + 1'b1) : rem_q;
                    if (neg) begin
                        if (quo_q > DW'(QMIN_MAG)) begin
                            q_d   = QMIN;
                            ovf_d = 1'b1;
                        end else begin
                            q_d   = ~quo_q[QW-1:0] + 1'b1;
                            ovf_d = 1'b0;
                        end
                    end else begin
                        if (quo_q > DW'(QMAX_MAG)) begin
                            q_d   = QMAX;
                            ovf_d = 1'b1;
                        end else begin
                            q_d   = quo_q[QW-1:0];
                            ovf_d = 1'b0;
                        end
                    end
                end
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            sn_q    <= 1'b0;
            sd_q    <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            sn_q    <= sn_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = vld_q;
    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_myproject_sdiv_20s_10s_12_seq.sv
module tb_myproject_sdiv_20s_10s_12_seq;
    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    myproject_sdiv_20s_10s_12_seq_if bus ();

    myproject_sdiv_20s_10s_12_seq dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    typedef struct {
        logic [11:0] q;
        logic [9:0]  r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int q, input int r, input bit dbz, input bit ovf);
        exp_t e;
        e.q = q[11:0]; e.r = r[9:0]; e.dbz = dbz; e.ovf = ovf;
        return e;
    endfunction

    // C-semantics reference: truncating division, remainder follows dividend.
    function automatic exp_t model(input int a, input int b);
        int q, r;
        if (b == 0) return mk((a >= 0) ? 2047 : -2048, 0, 1'b1, 1'b0);
        q = a / b;
        r = a % b;
        if (q > 2047)  return mk(2047, r, 1'b0, 1'b1);
        if (q < -2048) return mk(-2048, r, 1'b0, 1'b1);
        return mk(q, r, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input exp_t e);
        int w = 0;
        while (!bus.in_ready && w < 50) begin tick(); w++; end
        chk("in_ready_before_accept", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.dividend = a[19:0];
        bus.divisor  = b[9:0];
        sb.push_back(e);
        tick();
        // Operands may change freely once accepted.
        bus.in_valid = 1'b0;
        bus.dividend = 20'($urandom);
        bus.divisor  = 10'($urandom);
    endtask

    // exp_lat < 0 skips the latency check; hold = cycles of out_ready low.
    task automatic collect(input int exp_lat, input int hold);
        int   lat = 0;
        exp_t e;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        else              chk("out_valid_seen", 32'(bus.out_valid), 1);
        e = (sb.size() > 0) ? sb.pop_front() : mk(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < hold; i++) begin
            // New operands offered while busy must be ignored.
            bus.in_valid = 1'b1;
            bus.dividend = 20'($urandom);
            bus.divisor  = 10'($urandom);
            tick();
            chk("hold_out_valid", 32'(bus.out_valid), 1);
            chk("hold_in_ready",  32'(bus.in_ready), 0);
            chk("hold_quotient",  32'(bus.quotient), 32'(e.q));
        end
        bus.in_valid = 1'b0;
        chk("quotient",    32'(bus.quotient),    32'(e.q));
        chk("remainder",   32'(bus.remainder),   32'(e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        chk("overflow",    32'(bus.overflow),    32'(e.ovf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", 32'(bus.out_valid), 0);
        chk("in_ready_after", 32'(bus.in_ready), 1);
    endtask

    int   da[9] = '{1000, -1000, 1000, -1000, 100000, -524288, -4096, 500, -500};
    int   db[9] = '{7, 7, -7, -7, 3, -1, 2, 0, 0};
    int   eq[9] = '{142, -142, -142, 142, 2047, 2047, -2048, 2047, -2048};
    int   er[9] = '{6, -6, 6, -6, 1, 0, 0, 0, 0};
    bit   ez[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit   eo[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        logic [19:0] ra;
        logic [9:0]  rb;
        int          a, b, sel;

        ap_rst        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_quotient",  32'(bus.quotient), 0);
        chk("rst_remainder", 32'(bus.remainder), 0);
        ap_rst = 1'b0;

        // Directed sign/saturation/divide-by-zero cases with fixed latency.
        for (int i = 0; i < 9; i++) begin
            send(da[i], db[i], mk(eq[i], er[i], ez[i], eo[i]));
            collect(21, 0);
        end

        // Backpressure: result held for 10 cycles, busy input ignored.
        send(1000, 7, mk(142, 6, 1'b0, 1'b0));
        collect(21, 10);

        // Reset mid-calculation discards the operation.
        send(-1000, 7, mk(-142, -6, 1'b0, 1'b0));
        repeat (14) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        sb.delete();
        chk("midrst_in_ready",  32'(bus.in_ready), 1);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_quotient",  32'(bus.quotient), 0);
        chk("midrst_remainder", 32'(bus.remainder), 0);
        chk("midrst_dbz",       32'(bus.div_by_zero), 0);
        chk("midrst_ovf",       32'(bus.overflow), 0);
        send(1000, 7, mk(142, 6, 1'b0, 1'b0));
        collect(21, 0);

        // Random operands against the reference model with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            ra  = 20'($urandom);
            rb  = 10'($urandom);
            sel = $urandom_range(0, 9);
            a   = int'($signed(ra));
            if (sel == 0)      b = 0;
            else if (sel < 4)  b = $urandom_range(0, 40) - 20;
            else               b = int'($signed(rb));
            if (sel == 9)      a = $urandom_range(0, 8000) - 4000;
            send(a, b, model(a, b));
            collect(21, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
